// File: rtl/fxu_pkg.sv
// ---------------------------------------------------------------------------
// fxu_pkg
// Shared types and constants for the fixed-point unit reservation station.
//   - opcode constants (MOV, ADD, JEQ)
//   - field widths (TAG_W, DATA_W, OP_W, RANK_W)
//   - rs_entry_t : full contents of one reservation-station entry
//   - issue_t    : the fields an entry hands to the FXU when it issues
//   - snoopHit() : does a pending source match the current CDB broadcast
// ---------------------------------------------------------------------------
package fxu_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  // Ranks cover up to 8 entries (0 = oldest).
  localparam int RANK_W = 3;

  localparam logic [OP_W-1:0] OP_MOV = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_JEQ = 4'd6;

  typedef struct packed {
    logic              used;
    logic [OP_W-1:0]   op;
    logic              busy0;
    logic [TAG_W-1:0]  tag0;
    logic [DATA_W-1:0] val0;
    logic              busy1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val0;
    logic [DATA_W-1:0] val1;
  } issue_t;

  // A pending source picks up the CDB value when the broadcast tag matches.
  function automatic logic snoopHit(input logic             busy,
                                    input logic [TAG_W-1:0] tag,
                                    input logic             cdbValid,
                                    input logic [TAG_W-1:0] cdbTag);
    return busy && cdbValid && (tag == cdbTag);
  endfunction

endpackage

// File: rtl/fxu_rs_if.sv
// ---------------------------------------------------------------------------
// fxu_rs_if
// Bundles the dispatch, CDB, flush and FXU-issue signals of the reservation
// station.
//   master : the surrounding pipeline (dispatcher, CDB, FXU) - drives
//            flush, dispatch_*, cdb_*, fxu_busy; reads dispatch_ready,
//            dispatch_rs_num, issue_*
//   slave  : the reservation station itself (fxu_rs)
// ---------------------------------------------------------------------------
interface fxu_rs_if;
  import fxu_pkg::*;

  logic              flush;

  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [OP_W-1:0]   dispatch_op;
  logic              dispatch_busy0;
  logic              dispatch_busy1;
  logic [TAG_W-1:0]  dispatch_tag0;
  logic [TAG_W-1:0]  dispatch_tag1;
  logic [DATA_W-1:0] dispatch_val0;
  logic [DATA_W-1:0] dispatch_val1;
  logic [TAG_W-1:0]  dispatch_rs_num;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              fxu_busy;
  logic              issue_valid;
  logic [TAG_W-1:0]  issue_rs_num;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_val0;
  logic [DATA_W-1:0] issue_val1;

  modport master (
    output flush, dispatch_valid, dispatch_op, dispatch_busy0, dispatch_busy1,
           dispatch_tag0, dispatch_tag1, dispatch_val0, dispatch_val1,
           cdb_valid, cdb_tag, cdb_data, fxu_busy,
    input  dispatch_ready, dispatch_rs_num,
           issue_valid, issue_rs_num, issue_op, issue_val0, issue_val1
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_op, dispatch_busy0, dispatch_busy1,
           dispatch_tag0, dispatch_tag1, dispatch_val0, dispatch_val1,
           cdb_valid, cdb_tag, cdb_data, fxu_busy,
    output dispatch_ready, dispatch_rs_num,
           issue_valid, issue_rs_num, issue_op, issue_val0, issue_val1
  );

endinterface

// File: rtl/fxu_rs_entry.sv
// ---------------------------------------------------------------------------
// fxu_rs_entry
// One reservation-station slot: holds opcode and both operands, snoops the
// CDB for pending sources and reports when it is ready to issue.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush_i           drop the entry this cycle
//   alloc_i           load allocEntry_i (already CDB-captured by the bank)
//   allocEntry_i      new entry contents
//   free_i            entry issued this cycle, release it
//   cdbValid_i/Tag_i/Data_i  common data bus broadcast
//   used_o            slot is occupied
//   payload_o         op and operand values for the FXU
//   ready_o           occupied with both sources available
// ---------------------------------------------------------------------------
module fxu_rs_entry
  import fxu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  rs_entry_t         allocEntry_i,
  input  logic              free_i,
  input  logic              cdbValid_i,
  input  logic [TAG_W-1:0]  cdbTag_i,
  input  logic [DATA_W-1:0] cdbData_i,
  output logic              used_o,
  output issue_t            payload_o,
  output logic              ready_o
);

  rs_entry_t entry_q, entry_d;

  // Next-state: snoop first, then release/allocate, and flush overrides
  // everything. A ready entry has no busy source, so capture and issue
  // never apply to the same entry in one cycle.
  always_comb begin
    entry_d = entry_q;
    if (entry_q.used && snoopHit(entry_q.busy0, entry_q.tag0, cdbValid_i, cdbTag_i)) begin
      entry_d.busy0 = 1'b0;
      entry_d.val0  = cdbData_i;
    end
    if (entry_q.used && snoopHit(entry_q.busy1, entry_q.tag1, cdbValid_i, cdbTag_i)) begin
      entry_d.busy1 = 1'b0;
      entry_d.val1  = cdbData_i;
    end
    if (free_i) begin
      entry_d.used = 1'b0;
    end
    if (alloc_i) begin
      entry_d = allocEntry_i;
    end
    if (flush_i) begin
      entry_d.used = 1'b0;
    end
  end

  // Entry storage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign used_o         = entry_q.used;
  assign payload_o.op   = entry_q.op;
  assign payload_o.val0 = entry_q.val0;
  assign payload_o.val1 = entry_q.val1;
  assign ready_o        = entry_q.used && !entry_q.busy0 && !entry_q.busy1;

endmodule

// File: rtl/fxu_rs.sv
// ---------------------------------------------------------------------------
// fxu_rs
// Reservation-station bank in front of the fixed-point unit. Holds up to
// NUM_RS dispatched MOV/ADD/JEQ instructions until both sources are known,
// snoops the CDB, and issues the oldest ready entry each cycle.
// Parameters:
//   NUM_RS   number of entries (2..8)
//   RS_BASE  global rs_num of entry 0 (entry i is RS_BASE+i)
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         fxu_rs_if.slave: flush, dispatch_*, cdb_*, fxu_busy, issue_*
// Optional feature macro: FXU_RS_ISSUE_BYPASS_EN
//   When defined, a dispatch with both operands available issues in the same
//   cycle straight from the dispatch inputs if no stored entry is ready.
// ---------------------------------------------------------------------------
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int NUM_RS  = 4,
  parameter int RS_BASE = 0
) (
  input logic    clk,
  input logic    reset,
  fxu_rs_if.slave bus
);

  logic              usedVec  [NUM_RS];
  issue_t            payloads [NUM_RS];
  logic [NUM_RS-1:0] readyVec;
  logic [NUM_RS-1:0] allocOH;
  logic [NUM_RS-1:0] selOH;
  logic [RANK_W-1:0] rank_q [NUM_RS];
  logic [RANK_W-1:0] rank_d [NUM_RS];

  rs_entry_t         dispEntry;
  logic              freeFound;
  logic [TAG_W-1:0]  allocNum;
  logic              selFound;
  logic [RANK_W-1:0] selRank;
  logic [TAG_W-1:0]  selNum;
  issue_t            selPayload;
  logic [3:0]        usedCount;
  logic [RANK_W-1:0] newRank;
  logic              issueFire;
  logic              bypass;
  logic              accept;

  // Build the entry image for the offered instruction, folding in a CDB
  // broadcast that resolves one of its sources in the same cycle.
  always_comb begin
    dispEntry       = '0;
    dispEntry.used  = 1'b1;
    dispEntry.op    = bus.dispatch_op;
    dispEntry.tag0  = bus.dispatch_tag0;
    dispEntry.tag1  = bus.dispatch_tag1;
    dispEntry.busy0 = bus.dispatch_busy0;
    dispEntry.busy1 = bus.dispatch_busy1;
    dispEntry.val0  = bus.dispatch_val0;
    dispEntry.val1  = bus.dispatch_val1;
    if (snoopHit(bus.dispatch_busy0, bus.dispatch_tag0, bus.cdb_valid, bus.cdb_tag)) begin
      dispEntry.busy0 = 1'b0;
      dispEntry.val0  = bus.cdb_data;
    end
    if (snoopHit(bus.dispatch_busy1, bus.dispatch_tag1, bus.cdb_valid, bus.cdb_tag)) begin
      dispEntry.busy1 = 1'b0;
      dispEntry.val1  = bus.cdb_data;
    end
  end

  // Allocation picks the lowest-index free slot; occupancy count sets the
  // rank of a newly accepted instruction. Only registered state is used, so
  // a slot freed by this cycle's issue is not offered until next cycle.
  always_comb begin
    freeFound = 1'b0;
    allocOH   = '0;
    allocNum  = TAG_W'(RS_BASE);
    usedCount = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      usedCount = usedCount + 4'(usedVec[i]);
      if (!usedVec[i] && !freeFound) begin
        freeFound  = 1'b1;
        allocOH[i] = 1'b1;
        allocNum   = TAG_W'(RS_BASE + i);
      end
    end
  end

  // Select the ready entry with the lowest age rank (ranks are unique).
  always_comb begin
    selFound   = 1'b0;
    selRank    = '0;
    selOH      = '0;
    selNum     = '0;
    selPayload = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (readyVec[i] && (!selFound || rank_q[i] < selRank)) begin
        selFound   = 1'b1;
        selRank    = rank_q[i];
        selOH      = '0;
        selOH[i]   = 1'b1;
        selNum     = TAG_W'(RS_BASE + i);
        selPayload = payloads[i];
      end
    end
  end

`ifdef FXU_RS_ISSUE_BYPASS_EN
  assign bypass = !selFound && bus.dispatch_valid && freeFound && !bus.flush &&
                  !bus.fxu_busy && !dispEntry.busy0 && !dispEntry.busy1;
`else
  assign bypass = 1'b0;
`endif

  assign issueFire = selFound && !bus.fxu_busy && !bus.flush;
  assign accept    = bus.dispatch_valid && freeFound && !bus.flush && !bypass;
  assign newRank   = RANK_W'(usedCount - 4'(issueFire));

  assign bus.dispatch_ready  = freeFound;
  assign bus.dispatch_rs_num = allocNum;

  // Issue port: stored selection normally, dispatch inputs when bypassing.
  always_comb begin
    bus.issue_valid  = issueFire || bypass;
    bus.issue_rs_num = selNum;
    bus.issue_op     = selPayload.op;
    bus.issue_val0   = selPayload.val0;
    bus.issue_val1   = selPayload.val1;
    if (bypass) begin
      bus.issue_rs_num = allocNum;
      bus.issue_op     = dispEntry.op;
      bus.issue_val0   = dispEntry.val0;
      bus.issue_val1   = dispEntry.val1;
    end
  end

  // Age ranks: entries younger than the issued one move up by one; a newly
  // accepted entry goes behind everything that remains.
  always_comb begin
    for (int j = 0; j < NUM_RS; j++) begin
      rank_d[j] = rank_q[j];
      if (issueFire && usedVec[j] && !selOH[j] && rank_q[j] > selRank) begin
        rank_d[j] = rank_q[j] - 1'b1;
      end
      if (accept && allocOH[j]) begin
        rank_d[j] = newRank;
      end
    end
  end

  // Rank register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rank_q <= '{default: '0};
    end else begin
      rank_q <= rank_d;
    end
  end

  for (genvar g = 0; g < NUM_RS; g++) begin : gEntry
    fxu_rs_entry uEntry (
      .clk          (clk),
      .reset        (reset),
      .flush_i      (bus.flush),
      .alloc_i      (accept && allocOH[g]),
      .allocEntry_i (dispEntry),
      .free_i       (issueFire && selOH[g]),
      .cdbValid_i   (bus.cdb_valid),
      .cdbTag_i     (bus.cdb_tag),
      .cdbData_i    (bus.cdb_data),
      .used_o       (usedVec[g]),
      .payload_o    (payloads[g]),
      .ready_o      (readyVec[g])
    );
  end

endmodule

// File: doc/fxu_rs.md
# fxu_rs

Reservation-station bank that sits directly upstream of the fixed-point unit. It accepts dispatched MOV/ADD/JEQ instructions, holds them until both source operands are available, and snoops the common data bus (CDB) for pending tags. Each cycle it issues the oldest ready entry to the FXU, tagged with that entry's global RS number.

## Interface
- NUM_RS, 4: entries in the bank (2..8).
- RS_BASE, 0: global rs_num of entry 0; entry i has tag RS_BASE+i.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries this cycle
- dispatch_valid  in  1  new instruction offered
- dispatch_ready  out  1  at least one entry free
- dispatch_op  in  4  opcode: MOV=0, ADD=1, JEQ=6
- dispatch_busy0 / dispatch_busy1  in  1 each  source pending; value arrives later on CDB
- dispatch_tag0 / dispatch_tag1  in  6 each  producer rs_num when busy
- dispatch_val0 / dispatch_val1  in  16 each  operand value when not busy
- dispatch_rs_num  out  6  tag assigned to the offered instruction (valid when dispatch_ready)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  6  producer rs_num
- cdb_data  in  16  result value
- fxu_busy  in  1  FXU cannot accept; hold issue
- issue_valid  out  1  to FXU valid
- issue_rs_num  out  6  to FXU rs_num
- issue_op  out  4  to FXU op
- issue_val0 / issue_val1  out  16 each  to FXU operands

## Operation
- Entry state: used, op, busy0/tag0/val0, busy1/tag1/val1, age rank (0 = oldest).
- Allocation: lowest-index free entry; dispatch_rs_num = RS_BASE + that index. Accepted when dispatch_valid && dispatch_ready && !flush.
- Dispatch-time capture: if a dispatched source is busy and cdb_valid && cdb_tag equals its tag in the same cycle, it is stored not-busy with cdb_data.
- Snoop: every used entry with busyN && tagN==cdb_tag && cdb_valid captures cdb_data into valN and clears busyN.
- Ready = used && !busy0 && !busy1. MOV ignores src1; dispatcher presents busy1=0 for MOV.
- Select: among ready entries, lowest age rank. Issue occurs when a candidate exists, !fxu_busy, !flush. Issued entry is freed at that edge; ranks of younger entries decrement; new dispatch gets rank = count of remaining used entries.
- flush: clears all used bits; issue_valid forced 0; dispatch ignored.
- Full: dispatch_ready=0 even if an issue frees an entry this cycle; freed entry is usable next cycle.
- Reset: all entries free, ranks cleared; outputs: issue_valid=0, issue_rs_num=0, issue_op=0, issue_val0/1=0, dispatch_ready=1, dispatch_rs_num=RS_BASE.

## Timing
- All outputs are combinational from registered entry state (plus bypass path below); no combinational path from cdb_* to issue_*.
- Dispatch-to-issue latency with ready operands: 1 cycle (issue in cycle after acceptance).
- CDB-to-issue latency: captured at edge N, issuable in cycle N+1.
- fxu_busy high: selected entry held, issue_valid=0, no state lost; snoop continues.
- Simultaneous snoop and issue on different entries both take effect; an entry cannot both capture and issue in the same cycle.

## Configuration
- FXU_RS_ISSUE_BYPASS_EN defined: when no stored entry is ready, a dispatch whose operands are both not-busy (after dispatch-time capture) issues in the same cycle directly from dispatch_* inputs, is never written into an entry, and dispatch_ready is required true. Zero-cycle latency; adds a dispatch-to-issue combinational path.
- Undefined: no bypass; minimum latency 1 cycle as above.

## Structure
- Shared package fxu_pkg: opcode constants (MOV, ADD, JEQ), TAG_W=6, DATA_W=16, OP_W=4, entry struct typedef.
- One sub-module, fxu_rs_entry: single entry holding operands, CDB snoop/capture, ready output; the bank instantiates NUM_RS copies plus allocation, age ranking, and select logic.

## Test plan
- Dispatch ADD val0=3, val1=4 not busy after reset -> cycle later issue_valid=1, issue_rs_num=0, op=1, val0=3, val1=4; dispatch_ready stays 1.
- Dispatch MOV busy0 tag=9 into entry 0; CDB tag=9 data=0x00AA two cycles later -> issue next cycle with val0=0x00AA, rs_num=0.
- Fill 4 entries all waiting on tag 12 -> dispatch_ready=0; single CDB tag=12 data=5 -> entries issue oldest-first on 4 consecutive cycles, rs_num order 0,1,2,3.
- Dispatch JEQ busy1 tag=7 in same cycle as cdb_valid tag=7 data=0x1234 -> entry stored ready, issues next cycle with val1=0x1234.
- Two ready entries, fxu_busy=1 for 3 cycles -> issue_valid=0 for those cycles, then oldest issues first; no entry lost.
- flush with 3 entries used, one ready -> no issue that cycle; next cycle dispatch_ready=1, dispatch_rs_num=RS_BASE, issue_valid=0.
